// File: rtl/butterfly_unit_p_if.sv
// rtl/butterfly_unit_p_if.sv - signed-digit operand/result bus for butterfly_unit_p
interface butterfly_unit_p_if #(
  parameter int COEF_W = 14
);
  logic              in_sof;
  logic              xn2, xp, xpp;
  logic              yn2, yp, ypp;
  logic [COEF_W-1:0] P;
  logic [1:0]        mode;
  logic              o1_n2, o1_p, o1_pp;
  logic              o2_n2, o2_p, o2_pp;
  logic              out_sof;
  logic              out_valid;
  logic              sat_flag;
  logic              frame_err;

  modport master (
    output in_sof, xn2, xp, xpp, yn2, yp, ypp, P, mode,
    input  o1_n2, o1_p, o1_pp, o2_n2, o2_p, o2_pp,
    input  out_sof, out_valid, sat_flag, frame_err
  );

  modport slave (
    input  in_sof, xn2, xp, xpp, yn2, yp, ypp, P, mode,
    output o1_n2, o1_p, o1_pp, o2_n2, o2_p, o2_pp,
    output out_sof, out_valid, sat_flag, frame_err
  );
endinterface

// File: rtl/butterfly_unit_p.sv
// rtl/butterfly_unit_p.sv - framed digit-serial radix-2 butterfly with saturation
module butterfly_unit_p #(
  parameter int DIGITS = 8,
  parameter int COEF_W = 14,
  parameter int FRAC   = 12
) (
  input logic               clk,
  input logic               rst,
  butterfly_unit_p_if.slave bus
);
  localparam int AW = 2 * DIGITS + 1;
  localparam int RW = 2 * DIGITS;
  localparam int SW = AW + COEF_W + 2;
  localparam int CW = $clog2(DIGITS);
  localparam int OW = $clog2(DIGITS + 1);
  localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = (SW'(1) << (RW - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) << (RW - 1));

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic signed [AW-1:0]     x_acc, y_acc;
  logic signed [COEF_W-1:0] w_lat;
  logic [1:0]               mode_lat;
  logic                     done;
  logic                     frame_err_q;

  logic signed [AW-1:0]     xd, yd, x_sh, y_sh;
  logic signed [SW-1:0]     xs, ys, ws, prod, pm, a, b;
  logic [RW-1:0]            r1, r2;
  logic                     s1, s2;

  logic [AW-1:0]            sh1, sh2;
  logic [2:0]               o1_q, o2_q;
  logic [OW-1:0]            ocnt;
  logic                     valid_q, sof_q, sat_q;

  function automatic logic signed [2:0] dval(input logic [2:0] c);
    case (c)
      3'b010:  dval = 3'sd1;
      3'b001:  dval = 3'sd2;
      3'b100:  dval = -3'sd2;
      3'b110:  dval = -3'sd1;
      default: dval = 3'sd0;
    endcase
  endfunction

  // Booth window {r[2i+1], r[2i], r[2i-1]} to digit code {n2,p,pp}
  function automatic logic [2:0] enc(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: enc = 3'b010;
      3'b011:         enc = 3'b001;
      3'b100:         enc = 3'b100;
      3'b101, 3'b110: enc = 3'b110;
      default:        enc = 3'b000;
    endcase
  endfunction

  always_comb begin
    xd   = AW'(dval({bus.xn2, bus.xp, bus.xpp}));
    yd   = AW'(dval({bus.yn2, bus.yp, bus.ypp}));
    x_sh = xd <<< {cnt, 1'b0};
    y_sh = yd <<< {cnt, 1'b0};
  end

  // An in_sof seen while collecting always lands before the last digit, so it aborts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      x_acc       <= '0;
      y_acc       <= '0;
      w_lat       <= '0;
      mode_lat    <= '0;
      done        <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      done        <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.in_sof) begin
        frame_err_q <= (state == COLLECT);
        state       <= COLLECT;
        cnt         <= CW'(1);
        x_acc       <= xd;
        y_acc       <= yd;
        w_lat       <= bus.P;
        mode_lat    <= bus.mode;
      end else if (state == COLLECT) begin
        x_acc <= x_acc + x_sh;
        y_acc <= y_acc + y_sh;
        if (cnt == CW'(DIGITS - 1)) begin
          state <= IDLE;
          cnt   <= '0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Read during the cycle after the last digit, before a following frame overwrites the latches
  always_comb begin
    xs   = SW'(x_acc);
    ys   = SW'(y_acc);
    ws   = SW'(w_lat);
    prod = ys * ws;
    pm   = (prod + HALF) >>> FRAC;
    case (mode_lat)
      2'b01: begin a = xs; b = ys;  end
      2'b10: begin a = pm; b = -pm; end
      default: begin a = xs + pm; b = xs - pm; end
    endcase
    s1 = (a > MAXV) || (a < MINV);
    s2 = (b > MAXV) || (b < MINV);
    r1 = (a > MAXV) ? MAXV[RW-1:0] : ((a < MINV) ? MINV[RW-1:0] : a[RW-1:0]);
    r2 = (b > MAXV) ? MAXV[RW-1:0] : ((b < MINV) ? MINV[RW-1:0] : b[RW-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh1     <= '0;
      sh2     <= '0;
      o1_q    <= '0;
      o2_q    <= '0;
      ocnt    <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else if (done) begin
      sh1     <= {2'b00, r1[RW-1:1]};
      sh2     <= {2'b00, r2[RW-1:1]};
      o1_q    <= enc({r1[1:0], 1'b0});
      o2_q    <= enc({r2[1:0], 1'b0});
      ocnt    <= OW'(1);
      valid_q <= 1'b1;
      sof_q   <= 1'b1;
      sat_q   <= s1 | s2;
    end else begin
      sof_q <= 1'b0;
      sat_q <= 1'b0;
      if (valid_q && ocnt != OW'(DIGITS)) begin
        o1_q <= enc(sh1[2:0]);
        o2_q <= enc(sh2[2:0]);
        sh1  <= sh1 >> 2;
        sh2  <= sh2 >> 2;
        ocnt <= ocnt + OW'(1);
      end else begin
        valid_q <= 1'b0;
        o1_q    <= '0;
        o2_q    <= '0;
      end
    end
  end

  assign {bus.o1_n2, bus.o1_p, bus.o1_pp} = o1_q;
  assign {bus.o2_n2, bus.o2_p, bus.o2_pp} = o2_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_valid = valid_q;
  assign bus.sat_flag  = sat_q;
  assign bus.frame_err = frame_err_q;
endmodule
